// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg
//   Shared types and constants for the instruction-fetch front end.
//   WORD_BYTES and RESET_PC_DEFAULT are the values memory users agree on.
package ifetch_queue_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One queued instruction: fetched word plus the byte address it came from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // One stage of the read-latency tracker.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } trk_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifetch_fifo
//   Synchronous FIFO holding fetched {inst, pc} entries.
//   The head entry is read straight from the storage registers.
//   Flush has priority over push and pop in the same cycle.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_flush      empty the FIFO at this edge
//   i_push       write i_wdata (ignored when full)
//   i_wdata      entry to write
//   i_pop        drop the head entry (ignored when empty)
//   o_rdata      head entry
//   o_count      number of stored entries
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction-fetch front end for read port 0 of the simulation memory.
//   Issues sequential word addresses, tracks each request through the fixed
//   memory latency, queues returned words with their PCs and hands them
//   downstream over valid/ready. Issue is credit-limited so that every
//   in-flight request is guaranteed a queue slot. A redirect flushes the
//   tracker and queue and restarts fetch at the new PC.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   mem_raddr        registered word address to mem raddr0
//   mem_rdata        mem rdata0, MEM_LATENCY cycles after mem_raddr
//   redirect_valid   flush and restart at redirect_pc
//   redirect_pc      new fetch PC, bits [1:0] ignored
//   out_valid        queue head is valid
//   out_ready        consumer accepts the head
//   out_inst         head instruction word
//   out_pc           head instruction byte address
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          MEM_LATENCY = 2,
    parameter int          QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int QCW   = $clog2(QDEPTH) + 1;
    localparam int CNT_W = $clog2(QDEPTH + MEM_LATENCY + 1) + 1;

    logic [31:0]      r_fetch_pc;
    trk_entry_t       r_trk [MEM_LATENCY];
    logic [CNT_W-1:0] w_inflight;
    logic [QCW-1:0]   w_q_count;
    logic             w_q_full;
    logic             w_q_empty;
    logic             w_issue;
    logic             w_ret_valid;
    fetch_entry_t     w_ret_entry;
    fetch_entry_t     w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_trk[i].valid);
        end
    end

    // Counts are registered values, so a pop this cycle only frees its
    // credit once the FIFO count drops at the edge.
    assign w_issue = !redirect_valid && !w_q_full &&
                     ((w_inflight + CNT_W'(w_q_count)) < CNT_W'(QDEPTH));

    assign mem_raddr = r_fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= word_align(RESET_PC);
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_trk[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_trk[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
            end
            r_trk[0].valid <= w_issue;
            r_trk[0].pc    <= w_issue ? r_fetch_pc : 32'h0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_trk[i] <= r_trk[i-1];
            end
        end
    end

    assign w_ret_valid      = r_trk[MEM_LATENCY-1].valid;
    assign w_ret_entry.inst = mem_rdata;
    assign w_ret_entry.pc   = r_trk[MEM_LATENCY-1].pc;

    // The flush also drops the response arriving in the redirect cycle.
    ifetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_ret_valid),
        .i_wdata (w_ret_entry),
        .i_pop   (out_valid && out_ready),
        .o_rdata (w_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign out_valid = !w_q_empty;
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    // Memory contents: word at byte address a is (0x100 + a/4) ^ key.
    logic [31:0] key = 32'h0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (32'h100 + (a >> 2)) ^ key;
    endfunction

    // Two-cycle read pipeline, never stalls, not reset.
    logic [31:0] s1 = 32'h0;
    logic [31:0] s2 = 32'h0;
    always @(posedge clk) begin
        s1 <= memword(mem_raddr);
        s2 <= s1;
    end
    assign mem_rdata = s2;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: the stream is a sequence of consecutive PCs starting at
    // the last restart target; every accepted instruction must be the next one.
    logic [31:0] exp_pc     = 32'h0;
    logic [31:0] tgt        = 32'h0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_inst  = 32'h0;
    int          since      = 100;
    bit          stall_prev = 1'b0;
    int          ndeliv     = 0;

    // Called at a negedge: drive inputs for this cycle, check, advance model.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("raddr_align", {30'h0, mem_raddr[1:0]}, 32'h0);
        if (since >= 1 && since <= 3)
            chk("restart_gap_valid", 32'(out_valid), 32'h0);
        if (since == 4) begin
            chk("restart_valid", 32'(out_valid), 32'h1);
            chk("restart_pc", out_pc, tgt);
        end
        if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_pc", out_pc, prev_pc);
            chk("stall_inst", out_inst, prev_inst);
        end
        if (out_valid && rdy) begin
            chk("stream_pc", out_pc, exp_pc);
            chk("stream_inst", out_inst, memword(exp_pc));
            exp_pc = exp_pc + 32'h4;
            ndeliv++;
        end
        stall_prev = out_valid && !rdy && !rv;
        prev_pc    = out_pc;
        prev_inst  = out_inst;
        if (rv) begin
            exp_pc = rpc & ~32'h3;
            tgt    = exp_pc;
            since  = 1;
        end else if (since < 100) begin
            since++;
        end
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n      = 1'b1;
        exp_pc     = 32'h0;
        tgt        = 32'h0;
        since      = 1;
        stall_prev = 1'b0;
    endtask

    logic [31:0] wrap_exp [4];
    logic [31:0] held;
    int          n0;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_raddr", mem_raddr, 32'h0);

        // 1: first valid in cycle 3, then one per cycle
        release_reset();
        n0 = ndeliv;
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        repeat (8) cyc(1'b1, 1'b0, 32'h0);
        chk("throughput_start", 32'(ndeliv - n0), 32'd8);

        // 2: back-pressure: exactly QDEPTH outstanding, issue halts
        repeat (10) cyc(1'b0, 1'b0, 32'h0);
        chk("stall_raddr", mem_raddr, exp_pc + 32'd16);
        held = mem_raddr;
        cyc(1'b0, 1'b0, 32'h0);
        chk("stall_raddr_hold", mem_raddr, held);
        n0 = ndeliv;
        repeat (8) cyc(1'b1, 1'b0, 32'h0);
        chk("throughput_resume", 32'(ndeliv - n0), 32'd8);

        // 3: single redirect, low bits ignored
        cyc(1'b1, 1'b1, 32'h0000_0203);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        chk("redir_pc", out_pc, 32'h0000_0200);
        repeat (4) cyc(1'b1, 1'b0, 32'h0);

        // 4: back-to-back redirects, last wins
        cyc(1'b1, 1'b1, 32'h0000_0040);
        cyc(1'b1, 1'b1, 32'h0000_0080);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        chk("b2b_pc", out_pc, 32'h0000_0080);
        repeat (4) cyc(1'b1, 1'b0, 32'h0);

        // 5: address wrap
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pc", out_pc, wrap_exp[i]);
            cyc(1'b1, 1'b0, 32'h0);
        end

        // 6: reset mid-stream with three queued entries
        cyc(1'b0, 1'b1, 32'h0000_0300);
        repeat (5) cyc(1'b0, 1'b0, 32'h0);
        chk("pre_reset_pc", out_pc, 32'h0000_0300);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_pc", out_pc, 32'h0);
        chk("midrst_inst", out_inst, 32'h0);
        chk("midrst_raddr", mem_raddr, 32'h0);
        key = $urandom;
        @(negedge clk);
        release_reset();
        repeat (12) cyc(1'b1, 1'b0, 32'h0);

        // 7: randomized ready and redirects against the stream model
        n0 = ndeliv;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(99) < 70);
            rv  = ($urandom_range(99) < 3);
            if ($urandom_range(3) == 0)
                rpc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
            else
                rpc = $urandom;
            cyc(rdy, rv, rpc);
        end
        chk("random_progress", 32'((ndeliv - n0) > 1000), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
